switch_conditioner: RTL

//   Input-conditioning stage between the raw board switches (SWI) and the

---
 rtl/switch_conditioner.sv | 76 +++++++
 1 files changed

// File: rtl/switch_conditioner.sv
// Switch input conditioner: two-flop synchronizer, per-bit debounce and
// single-cycle rise/fall pulses on the debounced level, all in the clk_2 domain.
module switch_conditioner #(
  parameter int NBITS      = 8,
  parameter int DEB_CYCLES = 3
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] sw_raw,
  output logic [NBITS-1:0] sw_level,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall,
  output logic             changed
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [NBITS-1:0]            sync1_r;
  logic [NBITS-1:0]            sync2_r;
  logic [NBITS-1:0]            lvl_r;
  logic [NBITS-1:0]            lvl_prev_r;
  logic [NBITS-1:0][CNT_W-1:0] cnt_r;

  logic [NBITS-1:0]            lvl_nxt_s;
  logic [NBITS-1:0][CNT_W-1:0] cnt_nxt_s;

  // Two-flop synchronizer, nothing between the stages
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1_r <= {NBITS{1'b0}};
      sync2_r <= {NBITS{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce: a mismatch must persist DEB_CYCLES cycles before the level follows
  always_comb begin
    lvl_nxt_s = lvl_r;
    cnt_nxt_s = cnt_r;
    for (int i = 0; i < NBITS; i++) begin
      if (sync2_r[i] == lvl_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] >= CNT_LAST) begin
        lvl_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i] = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounce state and previous-level register for edge detection
  always_ff @(posedge clk_2) begin
    if (reset) begin
      cnt_r      <= '0;
      lvl_r      <= {NBITS{1'b0}};
      lvl_prev_r <= {NBITS{1'b0}};
    end else begin
      cnt_r      <= cnt_nxt_s;
      lvl_r      <= lvl_nxt_s;
      lvl_prev_r <= lvl_r;
    end
  end

  // Outputs depend on registers only; pulses mark the first cycle of a new level
  assign sw_level = lvl_r;
  assign sw_rise  = lvl_r & ~lvl_prev_r;
  assign sw_fall  = ~lvl_r & lvl_prev_r;
  assign changed  = |(sw_rise | sw_fall);

endmodule
